dcache_wb_multi_buffer: RTL
===========================

# dcache_wb_multi_buffer

Multi-entry, parametrised write-back buffer for the write-back data cache. It replaces the single-entry `writeback_t` holding register. Dirty victim lines are queued here on eviction, so the cache controller can refill immediately. Queued lines drain to main memory one word per granted beat, and a lookup port forwards queued line data back to the controller when an evicted line is re-requested before it has drained.

## Interface
Parameters:
- DEPTH, 2 — number of line entries (power of two, ≥2)
- LINE_WIDTH, 128 — cache line width in bits (ariane_pkg::DCACHE_LINE_WIDTH)
- WORD_WIDTH, 32 — memory beat width in bits (riscv::XLEN); LINE_WIDTH/WORD_WIDTH = WORDS, power of two
- ADDR_WIDTH, 34 — physical address width (riscv::PLEN)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- push_valid_i  in  1  victim line offered
- push_ready_o  out  1  buffer can accept a line
- push_addr_i  in  ADDR_WIDTH  victim address; offset bits ignored
- push_data_i  in  LINE_WIDTH  victim line data
- mem_req_o  out  1  write beat request
- mem_gnt_i  in  1  beat accepted by memory
- mem_addr_o  out  ADDR_WIDTH  word-aligned beat address
- mem_data_o  out  WORD_WIDTH  beat data
- mem_last_o  out  1  current beat is the final word of the line
- lookup_addr_i  in  ADDR_WIDTH  address probed by the cache controller
- lookup_hit_o  out  1  a queued line matches lookup_addr_i
- lookup_data_o  out  LINE_WIDTH  matching line data
- count_o  out  $clog2(DEPTH)+1  number of occupied entries
- empty_o  out  1  count_o == 0

## Operation
- Storage: circular FIFO of DEPTH entries, each holding {valid, line address, data}. Write and read pointers wrap modulo DEPTH.
- Stored address has its low $clog2(LINE_WIDTH/8) bits forced to zero.
- Push: accepted when push_valid_i && push_ready_o. push_ready_o = !full, independent of any pop in the same cycle, so there is no combinational path from mem_gnt_i.
- Drain FSM:
  - IDLE: mem_req_o=0. Go to SEND when empty_o==0.
  - SEND: mem_req_o=1. Head entry drives mem_addr_o = base + beat·(WORD_WIDTH/8), mem_data_o = data[beat·WORD_WIDTH +: WORD_WIDTH], mem_last_o = (beat==WORDS-1).
  - On mem_gnt_i: beat increments. On the last beat's grant: beat←0, head popped (valid cleared, read pointer advances). Stay in SEND if another entry remains after the pop, else go to IDLE.
- mem_addr_o, mem_data_o and mem_last_o are held stable while mem_req_o && !mem_gnt_i. mem_req_o is never withdrawn before grant.
- Lookup: purely combinational. Compare line-aligned lookup_addr_i against every valid entry.
  - Multiple matches (same line pushed twice): the youngest entry, nearest the write pointer, wins.
  - No hit: lookup_data_o = '0.
  - The head entry stays visible to lookup until its final beat is granted.
- count_o: +1 on push, −1 on pop, unchanged when push and pop occur in the same cycle.

## Timing
- Reset values: push_ready_o=1, mem_req_o=0, mem_addr_o=0, mem_data_o=0, mem_last_o=0, lookup_hit_o=0, lookup_data_o=0, count_o=0, empty_o=1. FSM in IDLE, beat=0, pointers=0, all valid bits clear.
- Push accepted at edge t:
  - The entry is visible to lookup and count_o in cycle t+1.
  - If the FSM was IDLE, mem_req_o rises in cycle t+1.
- Drain length: WORDS granted beats per line. With mem_gnt_i held high, one line drains in WORDS cycles, and back-to-back lines drain with no idle cycle between them.
- Full buffer plus final-beat grant in the same cycle: push is still refused (push_ready_o=0); the slot becomes available the next cycle.
- Reset asserted mid-drain: all entries are discarded immediately (asynchronous), mem_req_o drops with no further beats, and outputs return to reset values.

## Test plan
- Single push, addr 0x0_8000_0014, data words {W3..W0}=0x33/0x22/0x11/0x00, gnt tied high → beats at 0x8000_0010, 0x…14, 0x…18, 0x…1C with data 0x00, 0x11, 0x22, 0x33. mem_last_o on the 4th beat only. empty_o=1 one cycle after the 4th grant.
- Backpressure: gnt low 5 cycles on beat 1 → mem_req_o, mem_addr_o and mem_data_o stay constant through all 5 cycles, and no beat is skipped.
- Fill DEPTH=2, then push a 3rd line → push_ready_o=0 and the 3rd line is not stored. After the first line's last grant, push_ready_o=1 in the next cycle, count_o goes 2→1, and the 3rd push is accepted.
- Lookup forwarding: push line A=0x1000 and then A again with new data → lookup 0x1008 returns the newer data with hit=1. Lookup 0x2000 gives hit=0, data=0. After both copies of A drain, lookup 0x1000 gives hit=0.
- Simultaneous push and final-beat pop with count=1 → count_o stays 1, and the new line starts draining the next cycle with no idle gap.
- Assert rst_ni during beat 2 with 2 entries queued → mem_req_o=0 immediately, count_o=0, and no beats issued after reset is released.

Source files
------------

// File: rtl/dcache_wb_multi_buffer.sv
// Multi-entry write-back buffer: queues dirty victim lines, drains them one word per
// granted beat, and forwards queued line data to the controller on a lookup hit.
module dcache_wb_multi_buffer #(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 34
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_valid_i,
   output logic                         push_ready_o,
   input  logic [ADDR_WIDTH-1:0]        push_addr_i,
   input  logic [LINE_WIDTH-1:0]        push_data_i,
   output logic                         mem_req_o,
   input  logic                         mem_gnt_i,
   output logic [ADDR_WIDTH-1:0]        mem_addr_o,
   output logic [WORD_WIDTH-1:0]        mem_data_o,
   output logic                         mem_last_o,
   input  logic [ADDR_WIDTH-1:0]        lookup_addr_i,
   output logic                         lookup_hit_o,
   output logic [LINE_WIDTH-1:0]        lookup_data_o,
   output logic [$clog2(DEPTH):0]       count_o,
   output logic                         empty_o
);

   localparam int unsigned WORDS   = LINE_WIDTH / WORD_WIDTH;
   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned BEAT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned OFF_W   = $clog2(LINE_WIDTH / 8);
   localparam int unsigned BYTE_SH = $clog2(WORD_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t                r_state;
   logic [BEAT_W-1:0]     r_beat;
   logic [PTR_W-1:0]      r_rptr;
   logic [PTR_W-1:0]      r_wptr;
   logic [CNT_W-1:0]      r_count;
   logic                  r_valid [DEPTH];
   logic [ADDR_WIDTH-1:0] r_addr  [DEPTH];
   logic [LINE_WIDTH-1:0] r_data  [DEPTH];

   logic                  w_full;
   logic                  w_send;
   logic                  w_last;
   logic                  w_push;
   logic                  w_pop;
   logic [ADDR_WIDTH-1:0] w_lookup_line;
   logic [PTR_W-1:0]      w_idx;

   // Ready depends only on occupancy, so memory grant never reaches push_ready_o.
   assign w_full       = (r_count == CNT_W'(DEPTH));
   assign push_ready_o = !w_full;
   assign w_push       = push_valid_i && !w_full;
   assign w_send       = (r_state == S_SEND);
   assign w_last       = (r_beat == BEAT_W'(WORDS - 1));
   assign w_pop        = w_send && mem_gnt_i && w_last;

   assign mem_req_o  = w_send;
   assign mem_last_o = w_send && w_last;
   assign mem_addr_o = w_send ? (r_addr[r_rptr] + (ADDR_WIDTH'(r_beat) << BYTE_SH)) : '0;
   assign mem_data_o = w_send ? r_data[r_rptr][32'(r_beat) * WORD_WIDTH +: WORD_WIDTH] : '0;
   assign count_o    = r_count;
   assign empty_o    = (r_count == '0);

   // Drain sequencer: IDLE wakes on the push edge itself so the request rises one cycle later.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_push || (r_count != '0)) r_state <= S_SEND;
            end
            S_SEND: begin
               if (mem_gnt_i) begin
                  if (w_last) begin
                     r_beat <= '0;
                     r_rptr <= r_rptr + PTR_W'(1);
                     if ((r_count == CNT_W'(1)) && !w_push) r_state <= S_IDLE;
                  end else begin
                     r_beat <= r_beat + BEAT_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_push && !w_pop) r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_addr[i]  <= '0;
            r_data[i]  <= '0;
         end
      end else begin
         if (w_pop) r_valid[r_rptr] <= 1'b0;
         if (w_push) begin
            r_valid[r_wptr] <= 1'b1;
            r_addr[r_wptr]  <= push_addr_i & LINE_MASK;
            r_data[r_wptr]  <= push_data_i;
            r_wptr          <= r_wptr + PTR_W'(1);
         end
      end
   end

   // Scan oldest to youngest so the most recently queued copy of a line wins.
   assign w_lookup_line = lookup_addr_i & LINE_MASK;
   always_comb begin
      lookup_hit_o  = 1'b0;
      lookup_data_o = '0;
      w_idx         = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rptr + PTR_W'(k);
         if (r_valid[w_idx] && (r_addr[w_idx] == w_lookup_line)) begin
            lookup_hit_o  = 1'b1;
            lookup_data_o = r_data[w_idx];
         end
      end
   end

endmodule
